// File: rtl/hs_pkg.sv
// Shared types and helpers for the multi-channel start/done handshake controller.
package hs_pkg;

    // Per-channel handshake state
    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_START = 2'd1,
        HS_WAIT  = 2'd2,
        HS_ERR   = 2'd3
    } hs_state_t;

    // Widest vector popcount accepts; channel vectors are zero-extended to this
    localparam int POP_W = 32;

    // Number of set bits in a vector of up to POP_W bits
    function automatic int unsigned popcount(input logic [POP_W-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter: at most one one-hot grant per cycle, searching from the
// channel after the last grantee. The pointer only moves when a grant is issued.
module hs_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        // NOTE: every combinational output gets a default before the search loop, so no path leaves it unassigned and no latch is inferred.
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'((int'(idx) + 1) % N);
            end
        end
    end

    // Pointer moves to the channel after the grantee, only when a grant happens
    always_ff @(posedge clk or negedge rst_l) begin
        // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_l) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/handshake_array.sv
// Multi-channel start/done handshake controller. Each channel runs an
// IDLE/START/WAIT/ERR FSM; a shared round-robin arbiter issues at most one
// grant per cycle while fewer than MAX_ACTIVE channels are busy. A channel
// stuck in WAIT for TO_CYC cycles moves to ERR until clr_err.
module handshake_array
    import hs_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int TO_CYC     = 200
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ready,
    input  logic [NUM_CH-1:0]           done,
    input  logic                        clr_err,
    output logic [NUM_CH-1:0]           start,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           timeout,
    output logic [$clog2(NUM_CH+1)-1:0] active_cnt
);

    // Counter must hold TO_CYC-1; keep at least one bit when timeout is disabled
    localparam int CNT_W = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
    localparam int ACW   = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACW-1:0]   MAX_ACT = ACW'(MAX_ACTIVE);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] busy_d;
    logic [ACW-1:0]    active_q;
    logic              grant_en;

    // Admission uses the registered count, so a slot freed this cycle is
    // only reusable next cycle
    assign grant_en = enable && (active_q < MAX_ACT);

    hs_rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk   (clk),
        .rst_l (rst_l),
        .req   (req),
        .en    (grant_en),
        .gnt   (gnt)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hs_state_t        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             start_q;
        logic             busy_q;
        logic             err_q;
        logic             expire;

        // Last allowed WAIT cycle reached without done
        assign expire   = (TO_CYC > 0) && (state_q == HS_WAIT) && (cnt_q == TO_LAST);
        assign req[i]   = (state_q == HS_IDLE) && ready[i];
        // Busy next cycle: freshly granted, or still busy and neither done nor expiring
        assign busy_d[i] = gnt[i] || (busy_q && !done[i] && !expire);

        // Channel FSM with registered start/busy/timeout outputs
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                state_q <= HS_IDLE;
                cnt_q   <= '0;
                start_q <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                start_q <= 1'b0;
                busy_q  <= busy_d[i];
                case (state_q)
                    HS_IDLE: begin
                        if (gnt[i]) begin
                            state_q <= HS_START;
                            start_q <= 1'b1;
                        end
                    end
                    HS_START: begin
                        cnt_q   <= '0;
                        state_q <= done[i] ? HS_IDLE : HS_WAIT;
                    end
                    HS_WAIT: begin
                        // done has priority over an expiring timeout
                        if (done[i]) begin
                            state_q <= HS_IDLE;
                        end else if (expire) begin
                            state_q <= HS_ERR;
                            err_q   <= 1'b1;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HS_ERR: begin
                        if (clr_err) begin
                            state_q <= HS_IDLE;
                            err_q   <= 1'b0;
                        end
                    end
                    default: state_q <= HS_IDLE;
                endcase
            end
        end

        assign start[i]   = start_q;
        assign busy[i]    = busy_q;
        assign timeout[i] = err_q;
    end

    // Registered busy count, taken from next-cycle busy so it tracks busy exactly
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            active_q <= '0;
        end else begin
            active_q <= ACW'(popcount(POP_W'(busy_d)));
        end
    end

    assign active_cnt = active_q;

endmodule

// File: tb/tb_handshake_array.sv
// Directed testbench for handshake_array: reset, admission, round-robin order,
// timeout/clear, done-in-START, enable gating and asynchronous reset.
module tb_handshake_array;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       enable = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] ready = 4'h0;
    logic [3:0] done = 4'h0;

    logic [3:0] start, busy, timeout;
    logic [2:0] active_cnt;
    logic [3:0] start_t, busy_t, timeout_t;
    logic [2:0] active_cnt_t;

    int errors = 0;
    int checks = 0;

    // One stimulus row: inputs for a cycle and the outputs required next cycle
    typedef struct packed {
        logic [3:0] ready;
        logic [3:0] done;
        logic       en;
        logic       clr;
        logic [3:0] s;
        logic [3:0] b;
        logic [3:0] t;
        logic [2:0] c;
    } vec_t;

    always #5 clk = ~clk;

    handshake_array #(.NUM_CH(4), .MAX_ACTIVE(2), .TO_CYC(200)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .ready(ready), .done(done),
        .clr_err(clr_err), .start(start), .busy(busy), .timeout(timeout),
        .active_cnt(active_cnt)
    );

    handshake_array #(.NUM_CH(4), .MAX_ACTIVE(2), .TO_CYC(5)) dut_to (
        .clk(clk), .rst_l(rst_l), .enable(enable), .ready(ready), .done(done),
        .clr_err(clr_err), .start(start_t), .busy(busy_t), .timeout(timeout_t),
        .active_cnt(active_cnt_t)
    );

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic en,
                                input logic clr, input logic [3:0] s, input logic [3:0] b,
                                input logic [3:0] t, input logic [2:0] c);
        return {r, d, en, clr, s, b, t, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        ready   = v.ready;
        done    = v.done;
        enable  = v.en;
        clr_err = v.clr;
        step();
    endtask

    task automatic do_reset();
        rst_l = 1'b0; ready = 4'h0; done = 4'h0; enable = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (start !== 4'h0) begin errors++; $display("FAIL reset_start: got %b want 0000", start); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
        checks++; if (timeout !== 4'h0) begin errors++; $display("FAIL reset_timeout: got %b want 0000", timeout); end
        checks++; if (active_cnt !== 3'd0) begin errors++; $display("FAIL reset_active_cnt: got %0d want 0", active_cnt); end
    endtask

    // ready=1111 from reset: ch0 then ch1 start, then admission limit holds
    task automatic test_admission();
        vec_t tbl[$];
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0001, 4'b0001, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0010, 4'b0011, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0000, 4'b0011, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0000, 4'b0011, 4'h0, 3'd2));
        foreach (tbl[k]) begin
            apply(tbl[k]);
            checks++;
            if ({start, busy, timeout, active_cnt} !== {tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c}) begin
                errors++;
                $display("FAIL admission_row%0d: got start=%b busy=%b timeout=%b cnt=%0d want start=%b busy=%b timeout=%b cnt=%0d",
                         k, start, busy, timeout, active_cnt, tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c);
            end
        end
    endtask

    // Continues from test_admission: slots freed by done go to 2,3,0,1 in turn
    task automatic test_rr_release();
        vec_t tbl[$];
        tbl.push_back(mk(4'hF, 4'b0010, 1, 0, 4'b0000, 4'b0001, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'b0000, 1, 0, 4'b0100, 4'b0101, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'b0001, 1, 0, 4'b0000, 4'b0100, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'b0000, 1, 0, 4'b1000, 4'b1100, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'b0100, 1, 0, 4'b0000, 4'b1000, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'b0000, 1, 0, 4'b0001, 4'b1001, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'b1000, 1, 0, 4'b0000, 4'b0001, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'b0000, 1, 0, 4'b0010, 4'b0011, 4'h0, 3'd2));
        foreach (tbl[k]) begin
            apply(tbl[k]);
            checks++;
            if ({start, busy, timeout, active_cnt} !== {tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c}) begin
                errors++;
                $display("FAIL rr_row%0d: got start=%b busy=%b timeout=%b cnt=%0d want start=%b busy=%b timeout=%b cnt=%0d",
                         k, start, busy, timeout, active_cnt, tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c);
            end
        end
    endtask

    // TO_CYC=5 instance: expiry, done ignored in ERR, clear, done-at-expiry,
    // and clr_err coinciding with ERR entry
    task automatic test_timeout();
        vec_t tbl[$];
        do_reset();
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 4'h1, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        for (int n = 0; n < 4; n++) tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 4'h1, 3'd0));
        tbl.push_back(mk(4'h0, 4'h1, 1, 0, 4'h0, 4'h0, 4'h1, 3'd0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 3'd0));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 4'h1, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        for (int n = 0; n < 4; n++) tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 4'h1, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        for (int n = 0; n < 4; n++) tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 4'h0, 4'h0, 4'h1, 3'd0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 4'h1, 3'd0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 3'd0));
        foreach (tbl[k]) begin
            apply(tbl[k]);
            checks++;
            if ({start_t, busy_t, timeout_t, active_cnt_t} !== {tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c}) begin
                errors++;
                $display("FAIL timeout_row%0d: got start=%b busy=%b timeout=%b cnt=%0d want start=%b busy=%b timeout=%b cnt=%0d",
                         k, start_t, busy_t, timeout_t, active_cnt_t, tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c);
            end
        end
    endtask

    // done during START: one-cycle start, IDLE next cycle, regrant two cycles later
    task automatic test_back_to_back();
        vec_t tbl[$];
        do_reset();
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 4'h1, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h1, 4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 4'h1, 4'h1, 4'h0, 3'd1));
        tbl.push_back(mk(4'h0, 4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        tbl.push_back(mk(4'h0, 4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        foreach (tbl[k]) begin
            apply(tbl[k]);
            checks++;
            if ({start, busy, timeout, active_cnt} !== {tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c}) begin
                errors++;
                $display("FAIL b2b_row%0d: got start=%b busy=%b timeout=%b cnt=%0d want start=%b busy=%b timeout=%b cnt=%0d",
                         k, start, busy, timeout, active_cnt, tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c);
            end
        end
    endtask

    // enable=0 blocks new grants while busy channels finish; re-enable resumes RR
    task automatic test_enable();
        vec_t tbl[$];
        do_reset();
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0001, 4'b0001, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0010, 4'b0011, 4'h0, 3'd2));
        tbl.push_back(mk(4'hF, 4'h1, 0, 0, 4'b0000, 4'b0010, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h0, 0, 0, 4'b0000, 4'b0010, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h0, 0, 0, 4'b0000, 4'b0010, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h2, 0, 0, 4'b0000, 4'b0000, 4'h0, 3'd0));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b0100, 4'b0100, 4'h0, 3'd1));
        tbl.push_back(mk(4'hF, 4'h0, 1, 0, 4'b1000, 4'b1100, 4'h0, 3'd2));
        foreach (tbl[k]) begin
            apply(tbl[k]);
            checks++;
            if ({start, busy, timeout, active_cnt} !== {tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c}) begin
                errors++;
                $display("FAIL enable_row%0d: got start=%b busy=%b timeout=%b cnt=%0d want start=%b busy=%b timeout=%b cnt=%0d",
                         k, start, busy, timeout, active_cnt, tbl[k].s, tbl[k].b, tbl[k].t, tbl[k].c);
            end
        end
    endtask

    // Reset asserted mid-cycle while ch0 waits; pointer must restart at ch0
    task automatic test_async_reset();
        do_reset();
        apply(mk(4'h1, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        checks++; if (start !== 4'h1) begin errors++; $display("FAIL ar_grant: got start=%b want 0001", start); end
        apply(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        apply(mk(4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 3'd0));
        checks++; if (busy !== 4'h1) begin errors++; $display("FAIL ar_wait_busy: got busy=%b want 0001", busy); end
        #3;
        rst_l = 1'b0;
        #1;
        checks++;
        if ({start, busy, timeout, active_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL ar_immediate: got start=%b busy=%b timeout=%b cnt=%0d want all zero",
                     start, busy, timeout, active_cnt);
        end
        step();
        ready  = 4'hF;
        enable = 1'b1;
        rst_l  = 1'b1;
        step();
        checks++; if (start !== 4'b0001) begin errors++; $display("FAIL ar_first_grant: got start=%b want 0001", start); end
        checks++; if (active_cnt !== 3'd1) begin errors++; $display("FAIL ar_active_cnt: got %0d want 1", active_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_admission();
        test_rr_release();
        test_timeout();
        test_back_to_back();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
